// File: rtl/sw_onehot_arbiter_pkg.sv
// Shared types and helpers for the switch-to-one-hot arbiter (package sw_arb_pkg).
package sw_arb_pkg;
   localparam int N_LINES = 8;
   localparam int IDX_W   = 3;

   typedef logic [N_LINES-1:0] line_vec_t;
   typedef logic [IDX_W-1:0]   line_idx_t;

   function automatic line_vec_t onehot_from_idx(input line_idx_t idx);
      line_vec_t v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/sw_onehot_arbiter_if.sv
// Valid/ready handshake carrying one granted request as a one-hot vector.
interface sw_onehot_arbiter_if;
   import sw_arb_pkg::*;

   line_vec_t onehot_out;
   logic      out_valid;
   logic      out_ready;

   modport master (output onehot_out, output out_valid, input  out_ready);
   modport slave  (input  onehot_out, input  out_valid, output out_ready);
endinterface

// File: rtl/sw_onehot_arbiter_debounce.sv
// debounce_cell: two-flop synchronizer, debounce counter and stable flop for one switch line.
module debounce_cell #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic stable,
   output logic rise
);
   localparam int             CNT_W    = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] cnt;
   logic             flip;

   // flip is combinational so the caller can latch a press on the same edge stable changes
   assign flip = (sync_p1 != stable) && (cnt == CNT_LAST);
   assign rise = flip && !stable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         cnt     <= '0;
         stable  <= 1'b0;
      end else begin
         // stage p0 -> p1: metastability guard
         sync_p0 <= sw_raw;
         sync_p1 <= sync_p0;
         // debounce stage
         if (sync_p1 == stable) begin
            cnt <= '0;
         end else if (flip) begin
            cnt    <= '0;
            stable <= ~stable;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/sw_onehot_arbiter.sv
// Debounced switch bank feeding a one-request-at-a-time one-hot valid/ready output.
// Define SW_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (highest index).
module sw_onehot_arbiter
   import sw_arb_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  line_vec_t                  sw_in,
   sw_onehot_arbiter_if.master        out_if,
   output line_vec_t                  pending,
   output logic                       overrun
);
   line_vec_t stable_vec;
   line_vec_t rise_vec;
   line_vec_t clr_vec;
   line_idx_t gnt_idx;
   logic      gnt_found;
   logic      load;
   logic      grant;

   for (genvar i = 0; i < N_LINES; i++) begin : g_line
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .rst_n  (rst_n),
         .sw_raw (sw_in[i]),
         .stable (stable_vec[i]),
         .rise   (rise_vec[i])
      );
   end

`ifdef SW_ARB_ROUND_ROBIN_EN
   line_idx_t ptr;

   // Descending search starting just below the last grant, wrapping 0 -> 7
   always_comb begin
      line_idx_t cand;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_LINES; k++) begin
         cand = ptr - line_idx_t'(k);
         if (!gnt_found && pending[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end
`else
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = N_LINES - 1; k >= 0; k--) begin
         if (!gnt_found && pending[k]) begin
            gnt_found = 1'b1;
            gnt_idx   = line_idx_t'(k);
         end
      end
   end
`endif

   assign load    = !out_if.out_valid || out_if.out_ready;
   assign grant   = load && gnt_found;
   assign clr_vec = grant ? onehot_from_idx(gnt_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending           <= '0;
         overrun           <= 1'b0;
         out_if.onehot_out <= '0;
         out_if.out_valid  <= 1'b0;
      end else begin
         // a press landing on a bit being granted this edge re-arms it rather than overrunning
         pending <= (pending & ~clr_vec) | rise_vec;
         overrun <= |(rise_vec & pending & ~clr_vec);
         // output stage
         if (load) begin
            out_if.out_valid  <= gnt_found;
            out_if.onehot_out <= gnt_found ? onehot_from_idx(gnt_idx) : '0;
         end
      end
   end

`ifdef SW_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (grant) begin
         ptr <= gnt_idx;
      end
   end
`endif

   // The stable level is kept per line for observability; only the press pulse drives pending
   logic unused_stable;
   assign unused_stable = ^stable_vec;
endmodule

// File: tb/tb_sw_onehot_arbiter.sv
// Directed bench for sw_onehot_arbiter: vector table plus multi-cycle hand sequences.
module tb_sw_onehot_arbiter;
   logic       clk;
   logic       rst_n;
   logic [7:0] sw_in;
   logic [7:0] pending;
   logic       overrun;
   int         checks;
   int         errors;

   sw_onehot_arbiter_if bus ();

   sw_onehot_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_in   (sw_in),
      .out_if  (bus),
      .pending (pending),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [7:0] sw;
      logic       rdy;
      logic [7:0] oh;
      logic       vld;
      logic [7:0] pend;
      logic       ovr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int n, input bit rst, input logic [7:0] sw, input logic rdy,
                      input logic [7:0] oh, input logic vld, input logic [7:0] pend, input logic ovr);
      for (int i = 0; i < n; i++) begin
         vec_t v;
         v.rst = rst && (i == 0);
         v.sw = sw; v.rdy = rdy; v.oh = oh; v.vld = vld; v.pend = pend; v.ovr = ovr;
         tbl.push_back(v);
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] oh, input logic vld,
                          input logic [7:0] pend, input logic ovr);
      chk({tag, " onehot"},  bus.onehot_out, oh);
      chk({tag, " valid"},   {7'd0, bus.out_valid}, {7'd0, vld});
      chk({tag, " pending"}, pending, pend);
      chk({tag, " overrun"}, {7'd0, overrun}, {7'd0, ovr});
   endtask

   // Called at posedge+1; leaves the bench at posedge+4 with reset released
   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      sw_in = 8'h00;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk_all("reset", 8'h00, 1'b0, 8'h00, 1'b0);

      // Single press, ready high: grant after edge 7, drop after edge 8
      add(5, 1, 8'h04, 1, 8'h00, 0, 8'h00, 0);
      add(1, 0, 8'h04, 1, 8'h00, 0, 8'h04, 0);
      add(1, 0, 8'h04, 1, 8'h04, 1, 8'h00, 0);
      add(2, 0, 8'h04, 1, 8'h00, 0, 8'h00, 0);
      // Three-cycle glitch is rejected
      add(3, 1, 8'h02, 1, 8'h00, 0, 8'h00, 0);
      add(8, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
      // Two presses, stalled output, then release the stall
      add(5, 1, 8'hA0, 0, 8'h00, 0, 8'h00, 0);
      add(1, 0, 8'hA0, 0, 8'h00, 0, 8'hA0, 0);
      add(2, 0, 8'hA0, 0, 8'h80, 1, 8'h20, 0);
      add(1, 0, 8'hA0, 1, 8'h20, 1, 8'h00, 0);
      add(1, 0, 8'hA0, 1, 8'h00, 0, 8'h00, 0);

      for (int r = 0; r < tbl.size(); r++) begin
         if (tbl[r].rst) do_reset();
         sw_in = tbl[r].sw;
         bus.out_ready = tbl[r].rdy;
         step();
         chk_all($sformatf("row%0d", r), tbl[r].oh, tbl[r].vld, tbl[r].pend, tbl[r].ovr);
      end

      // Arbitration order with lines 7 and 0 both pending while the output holds 8'h80
      do_reset();
      sw_in = 8'h81;
      bus.out_ready = 1'b0;
      for (int e = 1; e <= 6; e++) step();
      chk("arb e6 pending", pending, 8'h81);
      step();
      chk_all("arb e7", 8'h80, 1'b1, 8'h01, 1'b0);
      sw_in = 8'h01;
      for (int e = 8; e <= 13; e++) step();
      sw_in = 8'h81;
      for (int e = 14; e <= 19; e++) step();
      chk_all("arb e19", 8'h80, 1'b1, 8'h81, 1'b0);
      bus.out_ready = 1'b1;
      step();
`ifdef SW_ARB_ROUND_ROBIN_EN
      chk_all("arb e20", 8'h01, 1'b1, 8'h80, 1'b0);
      step();
      chk_all("arb e21", 8'h80, 1'b1, 8'h00, 1'b0);
`else
      chk_all("arb e20", 8'h80, 1'b1, 8'h01, 1'b0);
      step();
      chk_all("arb e21", 8'h01, 1'b1, 8'h00, 1'b0);
`endif
      step();
      chk_all("arb e22", 8'h00, 1'b0, 8'h00, 1'b0);

      // Second press on pending line 3 while the output is stalled on line 7
      do_reset();
      sw_in = 8'h88;
      bus.out_ready = 1'b0;
      for (int e = 1; e <= 7; e++) step();
      chk_all("ovr e7", 8'h80, 1'b1, 8'h08, 1'b0);
      sw_in = 8'h80;
      for (int e = 8; e <= 13; e++) step();
      sw_in = 8'h88;
      for (int e = 14; e <= 18; e++) begin
         step();
         chk($sformatf("ovr quiet e%0d", e), {7'd0, overrun}, 8'h00);
      end
      step();
      chk_all("ovr e19", 8'h80, 1'b1, 8'h08, 1'b1);
      step();
      chk_all("ovr e20", 8'h80, 1'b1, 8'h08, 1'b0);

      // Asynchronous reset mid-cycle while a grant is held
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async rst", 8'h00, 1'b0, 8'h00, 1'b0);
      #2;
      rst_n = 1'b1;
      for (int e = 1; e <= 5; e++) step();
      chk("rearm e5 pending", pending, 8'h00);
      step();
      chk("rearm e6 pending", pending, 8'h88);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
